ddr_read_uart_serializer: RTL and testbench

//   Consumes 256-bit DDR3 read-data words from the read-data stage and emits them
//   as a byte stream to the UART transmitter over a valid/ready handshake.

---
 rtl/ddr_read_uart_serializer.sv | 89 ++++++++
 tb/tb_ddr_read_uart_serializer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_read_uart_serializer.sv
// ddr_read_uart_serializer: streams DATA_W-bit DDR3 read words to uart_tx as bytes, with an optional XOR checksum byte
module ddr_read_uart_serializer #(
    parameter int DATA_W      = 256,
    parameter bit MSB_FIRST   = 1'b1,
    parameter bit APPEND_CSUM = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              word_done,
    output logic              busy,
    output logic [CNT_W-1:0]  word_count
);
    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = NBYTES > 1 ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        csum;
    logic              accept, hs, last;

    function automatic logic [7:0] head(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1 -: 8] : w[7:0];
    endfunction

    function automatic logic [DATA_W-1:0] shift(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w << 8 : w >> 8;
    endfunction

    assign in_ready = reset && state == IDLE;
    assign accept   = in_valid && in_ready;
    assign hs       = tx_valid && tx_ready;
    assign last     = hs && (state == CSUM || (state == SEND && idx == LAST && !APPEND_CSUM));
    assign busy     = tx_valid;

    always_ff @(posedge clk)
        if (!reset) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SEND;
            SEND:    if (hs && idx == LAST) state_nxt = APPEND_CSUM ? CSUM : IDLE;
            CSUM:    if (hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // tx_data always holds the byte on offer, so it stays put through stalls
    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg      <= '0;
            idx        <= '0;
            csum       <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            word_done  <= 1'b0;
            word_count <= '0;
        end else begin
            tx_valid   <= state_nxt != IDLE;
            word_done  <= last;
            word_count <= word_count + CNT_W'(last);
            if (accept) begin
                shreg   <= shift(in_data);
                tx_data <= head(in_data);
                idx     <= '0;
                csum    <= '0;
            end else if (hs && state == SEND) begin
                csum    <= csum ^ tx_data;
                idx     <= idx + 1'b1;
                shreg   <= shift(shreg);
                tx_data <= idx == LAST ? (APPEND_CSUM ? csum ^ tx_data : 8'h00) : head(shreg);
            end else if (hs) begin
                tx_data <= 8'h00;
            end
        end
    end
endmodule

// File: tb/tb_ddr_read_uart_serializer.sv
// tb_ddr_read_uart_serializer: randomized checks of both byte orders against a byte-queue reference model
module tb_ddr_read_uart_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [255:0] in_data_a, in_data_b;
    logic         in_valid_a, in_valid_b, tx_ready_a, tx_ready_b;
    logic         in_ready_a, in_ready_b, tx_valid_a, tx_valid_b;
    logic         word_done_a, word_done_b, busy_a, busy_b;
    logic [7:0]   tx_data_a, tx_data_b;
    logic [15:0]  word_count_a;
    logic [1:0]   word_count_b;

    int pass = 0, total = 0, wc_a = 0;
    logic [7:0] q[$];

    ddr_read_uart_serializer #(.DATA_W(256), .MSB_FIRST(1'b1), .APPEND_CSUM(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .word_done(word_done_a),
        .busy(busy_a), .word_count(word_count_a));

    ddr_read_uart_serializer #(.DATA_W(256), .MSB_FIRST(1'b0), .APPEND_CSUM(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .word_done(word_done_b),
        .busy(busy_b), .word_count(word_count_b));

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
        return w;
    endfunction

    // expected byte stream of one word: data bytes in wire order, then XOR of them if requested
    task automatic model_bytes(input logic [255:0] w, input bit msb, input bit cs);
        logic [7:0] b, x;
        x = 8'h00;
        for (int k = 0; k < 32; k++) begin
            b = msb ? w[8*(31-k) +: 8] : w[8*k +: 8];
            q.push_back(b);
            x ^= b;
        end
        if (cs) q.push_back(x);
    endtask

    task automatic test_reset;
        logic [255:0] w;
        w = rand_word();
        q.delete();
        model_bytes(w, 1'b1, 1'b1);
        reset = 1'b0; in_data_a = w; in_valid_a = 1'b1; tx_ready_a = 1'b1;
        in_data_b = '0; in_valid_b = 1'b0; tx_ready_b = 1'b0;
        repeat (2) @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (in_ready_a !== 1'b0 || tx_valid_a !== 1'b0 || busy_a !== 1'b0 || word_done_a !== 1'b0) $display("FAIL reset_flags in_ready=%b tx_valid=%b busy=%b word_done=%b want 0000", in_ready_a, tx_valid_a, busy_a, word_done_a); else pass++;
            total++; if (tx_data_a !== 8'h00 || word_count_a !== 16'd0) $display("FAIL reset_values tx_data=%h word_count=%0d want 00/0", tx_data_a, word_count_a); else pass++;
            total++; if (tx_valid_b !== 1'b0 || word_count_b !== 2'd0) $display("FAIL reset_b tx_valid=%b word_count=%0d want 0/0", tx_valid_b, word_count_b); else pass++;
        end
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        total++; if (in_ready_a !== 1'b1 || tx_valid_a !== 1'b0) $display("FAIL reset_release in_ready=%b tx_valid=%b want 1/0", in_ready_a, tx_valid_a); else pass++;
        @(negedge clk);
        total++; if (tx_valid_a !== 1'b1 || tx_data_a !== q[0] || in_ready_a !== 1'b0) $display("FAIL reset_first_accept tx_valid=%b tx_data=%h in_ready=%b want 1/%h/0", tx_valid_a, tx_data_a, in_ready_a, q[0]); else pass++;
        @(posedge clk); #1; in_valid_a = 1'b0; reset = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        total++; if (tx_valid_a !== 1'b0 || word_count_a !== 16'd0) $display("FAIL reset_abort tx_valid=%b word_count=%0d want 0/0", tx_valid_a, word_count_a); else pass++;
        wc_a = 0;
    endtask

    task automatic test_stream;
        logic [255:0] w;
        logic [7:0]   prev;
        bit           stall, last_hs, stalled, done;
        int           n;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 32; k++) w[8*k +: 8] = 8'(k);
            if (s == 1) w = {32{8'hA5}};
            else if (s > 1) w = rand_word();
            stall = s != 0;
            q.delete();
            model_bytes(w, 1'b1, 1'b1);
            @(posedge clk); #1; in_data_a = w; in_valid_a = 1'b1; tx_ready_a = 1'b1;
            @(negedge clk);
            total++; if (in_ready_a !== 1'b1) $display("FAIL stream_idle_ready s=%0d got %b want 1", s, in_ready_a); else pass++;
            @(posedge clk); #1;
            in_valid_a = 1'b0;
            in_data_a = rand_word();
            tx_ready_a = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            n = 0; last_hs = 0; stalled = 0; done = 0; prev = 8'h00;
            for (int c = 0; c < 400 && !done; c++) begin
                @(negedge clk);
                total++; if (word_done_a !== last_hs) $display("FAIL stream_word_done s=%0d c=%0d got %b want %b", s, c, word_done_a, last_hs); else pass++;
                if (last_hs) begin
                    wc_a++;
                    total++; if (word_count_a !== 16'(wc_a)) $display("FAIL stream_word_count s=%0d got %0d want %0d", s, word_count_a, wc_a); else pass++;
                    if (!stall) begin
                        total++; if (c != 33) $display("FAIL stream_cycles s=%0d got %0d want 33", s, c); else pass++;
                    end
                    done = 1;
                end else begin
                    total++; if (tx_valid_a !== 1'b1 || busy_a !== 1'b1 || in_ready_a !== 1'b0) $display("FAIL stream_flags s=%0d c=%0d tx_valid=%b busy=%b in_ready=%b want 110", s, c, tx_valid_a, busy_a, in_ready_a); else pass++;
                    if (stalled) begin
                        total++; if (tx_data_a !== prev) $display("FAIL stream_stall_stable s=%0d c=%0d got %h want %h", s, c, tx_data_a, prev); else pass++;
                    end
                    if (tx_valid_a && tx_ready_a) begin
                        total++; if (tx_data_a !== q[n]) $display("FAIL stream_byte s=%0d n=%0d got %h want %h", s, n, tx_data_a, q[n]); else pass++;
                        last_hs = n == q.size() - 1;
                        n++;
                        stalled = 0;
                    end else begin
                        stalled = 1;
                        prev = tx_data_a;
                    end
                    @(posedge clk); #1;
                    tx_ready_a = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
            end
            if (!done) begin
                total++; $display("FAIL stream_timeout s=%0d bytes got %0d want %0d", s, n, q.size());
            end
        end
    endtask

    task automatic test_lsb_nocsum;
        logic [255:0] w;
        logic [7:0]   prev;
        bit           stall, last_hs, stalled, done;
        int           n;
        for (int s = 0; s < 5; s++) begin
            w = s == 0 ? 256'd1 : rand_word();
            stall = s >= 2;
            q.delete();
            model_bytes(w, 1'b0, 1'b0);
            @(posedge clk); #1; in_data_b = w; in_valid_b = 1'b1; tx_ready_b = 1'b1;
            @(posedge clk); #1;
            in_valid_b = 1'b0;
            in_data_b = rand_word();
            tx_ready_b = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
            n = 0; last_hs = 0; stalled = 0; done = 0; prev = 8'h00;
            for (int c = 0; c < 400 && !done; c++) begin
                @(negedge clk);
                total++; if (word_done_b !== last_hs) $display("FAIL lsb_word_done s=%0d c=%0d got %b want %b", s, c, word_done_b, last_hs); else pass++;
                if (last_hs) begin
                    total++; if (word_count_b !== 2'(s + 1)) $display("FAIL lsb_word_count_wrap s=%0d got %0d want %0d", s, word_count_b, (s + 1) % 4); else pass++;
                    total++; if (tx_valid_b !== 1'b0) $display("FAIL lsb_no_csum s=%0d tx_valid got %b want 0", s, tx_valid_b); else pass++;
                    if (!stall) begin
                        total++; if (c != 32) $display("FAIL lsb_cycles s=%0d got %0d want 32", s, c); else pass++;
                    end
                    done = 1;
                end else begin
                    total++; if (tx_valid_b !== 1'b1 || in_ready_b !== 1'b0) $display("FAIL lsb_flags s=%0d c=%0d tx_valid=%b in_ready=%b want 10", s, c, tx_valid_b, in_ready_b); else pass++;
                    if (stalled) begin
                        total++; if (tx_data_b !== prev) $display("FAIL lsb_stall_stable s=%0d c=%0d got %h want %h", s, c, tx_data_b, prev); else pass++;
                    end
                    if (tx_valid_b && tx_ready_b) begin
                        total++; if (tx_data_b !== q[n]) $display("FAIL lsb_byte s=%0d n=%0d got %h want %h", s, n, tx_data_b, q[n]); else pass++;
                        last_hs = n == q.size() - 1;
                        n++;
                        stalled = 0;
                    end else begin
                        stalled = 1;
                        prev = tx_data_b;
                    end
                    @(posedge clk); #1;
                    tx_ready_b = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
                end
            end
            if (!done) begin
                total++; $display("FAIL lsb_timeout s=%0d bytes got %0d want %0d", s, n, q.size());
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [255:0] w1, w2;
        int n;
        w1 = rand_word();
        w2 = rand_word();
        q.delete();
        model_bytes(w1, 1'b1, 1'b1);
        model_bytes(w2, 1'b1, 1'b1);
        n = 0;
        @(posedge clk); #1; in_data_a = w1; in_valid_a = 1'b1; tx_ready_a = 1'b1;
        @(negedge clk);
        total++; if (in_ready_a !== 1'b1) $display("FAIL b2b_idle_ready got %b want 1", in_ready_a); else pass++;
        @(posedge clk); #1; in_data_a = w2;
        for (int c = 0; c < 67; c++) begin
            @(negedge clk);
            if (c == 33) begin
                total++; if (tx_valid_a !== 1'b0 || in_ready_a !== 1'b1 || word_done_a !== 1'b1) $display("FAIL b2b_bubble tx_valid=%b in_ready=%b word_done=%b want 011", tx_valid_a, in_ready_a, word_done_a); else pass++;
                total++; if (word_count_a !== 16'(wc_a + 1)) $display("FAIL b2b_count_first got %0d want %0d", word_count_a, wc_a + 1); else pass++;
            end else begin
                total++; if (tx_valid_a !== 1'b1 || tx_data_a !== q[n]) $display("FAIL b2b_byte c=%0d tx_valid=%b tx_data=%h want 1/%h", c, tx_valid_a, tx_data_a, q[n]); else pass++;
                total++; if (in_ready_a !== 1'b0) $display("FAIL b2b_in_ready_busy c=%0d got %b want 0", c, in_ready_a); else pass++;
                n++;
            end
            @(posedge clk); #1;
            if (c == 33) in_valid_a = 1'b0;
        end
        @(negedge clk);
        wc_a += 2;
        total++; if (word_done_a !== 1'b1 || word_count_a !== 16'(wc_a)) $display("FAIL b2b_end word_done=%b word_count=%0d want 1/%0d", word_done_a, word_count_a, wc_a); else pass++;
    endtask

    task automatic test_mid_reset;
        logic [255:0] w;
        w = rand_word();
        q.delete();
        model_bytes(w, 1'b1, 1'b1);
        @(posedge clk); #1; in_data_a = w; in_valid_a = 1'b1; tx_ready_a = 1'b1;
        @(posedge clk); #1; in_valid_a = 1'b0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            total++; if (tx_valid_a !== 1'b1 || tx_data_a !== q[c]) $display("FAIL midrst_pre_byte c=%0d tx_valid=%b tx_data=%h want 1/%h", c, tx_valid_a, tx_data_a, q[c]); else pass++;
        end
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        total++; if (tx_valid_a !== 1'b0 || word_count_a !== 16'd0 || word_done_a !== 1'b0) $display("FAIL midrst_abort tx_valid=%b word_count=%0d word_done=%b want 0/0/0", tx_valid_a, word_count_a, word_done_a); else pass++;
        wc_a = 0;
        w = rand_word();
        q.delete();
        model_bytes(w, 1'b1, 1'b1);
        @(posedge clk); #1; in_data_a = w; in_valid_a = 1'b1;
        @(posedge clk); #1; in_valid_a = 1'b0;
        for (int c = 0; c < 33; c++) begin
            @(negedge clk);
            total++; if (tx_valid_a !== 1'b1 || tx_data_a !== q[c]) $display("FAIL midrst_restart_byte c=%0d tx_valid=%b tx_data=%h want 1/%h", c, tx_valid_a, tx_data_a, q[c]); else pass++;
        end
        @(negedge clk);
        total++; if (word_done_a !== 1'b1 || word_count_a !== 16'd1) $display("FAIL midrst_restart_done word_done=%b word_count=%0d want 1/1", word_done_a, word_count_a); else pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_lsb_nocsum();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
